div5_rr_sched: RTL and testbench
================================

Name: div5_rr_sched

Overview:
- Pipelined scheduler that shares one combinational 64-bit divide-by-5 datapath (the team's div_64_5, ports X[64:1] in, Q[62:1] out) between NREQ requesters.
- Round-robin arbitration picks one request per cycle, registers the operand, and registers the quotient on the far side of the datapath.
- Each result returns on a single response channel, tagged with the requester ID.
- Sits between the multi-channel scaling front-end and the single shared divider, so the divider's LUT cost is paid once.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester ID width; must satisfy 2^IDW >= NREQ

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  per-requester request valid
- req_x  input  NREQ*64  operands; requester i occupies bits [64*i+63 : 64*i]
- req_ready  output  NREQ  one-hot or zero; request i accepted when req_valid[i] & req_ready[i]
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer ready
- rsp_q  output  62  floor(X/5)
- rsp_id  output  IDW  index of the requester that issued X
- busy  output  1  high when either pipe stage holds data

Behaviour:
- Reset (async assert, sync deassert by design):
  - Stage valids va=vb=0 and round-robin pointer ptr=0.
  - All data and ID registers 0.
  - rsp_valid=0, busy=0, req_ready=0.
- Stage A (issue register): xa[63:0], ida, va. Stage B (result register): qb[61:0], idb, vb.
- Datapath: the div_64_5 instance is fed from xa; its Q is captured into qb. No other logic sits between stage A and stage B.
- Pipe occupancy states (derived from va, vb):
  - EMPTY (0,0)
  - A_ONLY (1,0)
  - B_ONLY (0,1)
  - FULL (1,1)
- Flow rules:
  - drain_b = vb & rsp_ready.
  - adv_a = va & (~vb | drain_b): stage A moves into stage B.
  - can_accept = ~va | adv_a.
  - vb_next = adv_a | (vb & ~drain_b).
  - va_next = grant_any | (va & ~adv_a).
- Arbitration:
  - Grant goes to the first i with req_valid[i] set, searching ptr, ptr+1, ... mod NREQ.
  - req_ready[i] = grant[i] & can_accept. It is combinational from req_valid, ptr and pipe state; it never depends on rsp_q.
  - On an accepted request, ptr <= (granted index + 1) mod NREQ. Otherwise ptr holds.
  - No grant if no valid request or if can_accept=0.
- Latency:
  - A request accepted in cycle t gives rsp_valid=1 in cycle t+2, provided stage B is free.
  - Throughput is 1 result/cycle while rsp_ready=1.
- Outputs: rsp_valid=vb, rsp_q=qb, rsp_id=idb, busy=va|vb.
- Stall and hold:
  - While rsp_valid=1 and rsp_ready=0, rsp_q and rsp_id hold stable.
  - Stage A holds, and req_ready goes all-zero once the pipe is FULL.
- Simultaneous events:
  - In FULL with rsp_ready=1, drain, advance and accept all happen in the same cycle, with no bubble.
- Correctness:
  - rsp_q equals floor(X/5) for every 64-bit X. The maximum quotient is 0x3333_3333_3333_3333, which fits in 62 bits.
  - Responses leave in acceptance order.
- Requester protocol: req_valid[i] must not depend on req_ready[i]. Once asserted, req_x[i] holds until accepted.
- Reset mid-operation: in-flight entries are discarded with no response, and ptr returns to 0.
- NREQ not a power of two: pointer wrap is explicit mod NREQ. IDs >= NREQ are never produced.

Optional Feature:
- Macro: DIV5_SCHED_REM_OUT_EN.
- When defined:
  - Adds output rsp_r [2:0] = X - 5*Q, range 0..4.
  - A 3-bit copy of X[2:0] travels with stage A and is captured alongside qb.
  - rsp_r is computed from the low bits (x_lo - 5*q_lo mod 8) at stage A and registered in stage B, aligned with rsp_q.
  - Reset value 0.
- When undefined: the rsp_r port and its registers do not exist. All other behaviour is identical.

Test Plan:
- Single request: req 0, X=100, rsp_ready=1 -> rsp_valid two cycles after acceptance, rsp_q=20, rsp_id=0, busy low one cycle after the response.
- Extreme operands:
  - X=0xFFFF_FFFF_FFFF_FFFF -> rsp_q=0x3333_3333_3333_3333.
  - X=4 -> rsp_q=0.
  - X=5 -> rsp_q=1.
- Round robin: all 4 req_valid held high with distinct X, rsp_ready=1 -> grants and rsp_id sequence 0,1,2,3,0,1 with one result per cycle.
- Backpressure: continuous requests, rsp_ready=0 for 5 cycles -> rsp_q/rsp_id stable, req_ready all-zero after 2 accepts, no loss or duplication after release, order preserved.
- Reset mid-flight: assert rst_n=0 while the pipe is FULL -> rsp_valid=0 and busy=0 immediately (asynchronous), ptr=0, no stale response after release.
- With DIV5_SCHED_REM_OUT_EN:
  - X=14 -> rsp_q=2, rsp_r=4.
  - X=0xFFFF_FFFF_FFFF_FFFF -> rsp_r=0.
  - Random 10k operands checked against floor division and modulo.

Source files
------------

// File: rtl/div5_rr_sched.sv
// Round-robin scheduler sharing one combinational divide-by-5 datapath between NREQ requesters.
// Optional remainder output enabled by defining DIV5_SCHED_REM_OUT_EN.

// Combinational floor(X/5) using restoring long division, one quotient bit per dividend bit.
module div_64_5 (
    input  logic [64:1] X,
    output logic [62:1] Q
);

    logic [2:0] w_rem;
    logic [3:0] w_trial;

    // The top two dividend bits can never yield a quotient bit, so they seed the remainder.
    always_comb begin
        w_rem   = {1'b0, X[64:63]};
        w_trial = '0;
        Q       = '0;
        for (int i = 62; i >= 1; i--) begin
            w_trial = {w_rem, X[i]};
            if (w_trial >= 4'd5) begin
                Q[i]  = 1'b1;
                w_rem = 3'(w_trial - 4'd5);
            end else begin
                w_rem = w_trial[2:0];
            end
        end
    end

endmodule

module div5_rr_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*64-1:0]   req_x,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [61:0]          rsp_q,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
`ifdef DIV5_SCHED_REM_OUT_EN
    ,
    output logic [2:0]           rsp_r
`endif
);

    localparam int unsigned XW = 64;
    localparam int unsigned QW = 62;
    localparam int unsigned SW = IDW + 1;

    logic [XW-1:0]     r_xa;
    logic [IDW-1:0]    r_ida;
    logic              r_va;
    logic [QW-1:0]     r_qb;
    logic [IDW-1:0]    r_idb;
    logic              r_vb;
    logic [IDW-1:0]    r_ptr;

    logic [2*NREQ-1:0] w_rot2;
    logic [NREQ-1:0]   w_rot;
    logic [NREQ-1:0]   w_grant;
    logic              w_grant_any;
    logic [IDW-1:0]    w_gidx;
    logic [SW-1:0]     w_sum;
    logic [IDW-1:0]    w_ptr_nxt;
    logic [XW-1:0]     w_xsel;
    logic [QW-1:0]     w_q;
    logic              w_drain_b;
    logic              w_adv_a;
    logic              w_can_accept;
    logic              w_accept;

`ifdef DIV5_SCHED_REM_OUT_EN
    logic [2:0]        r_rb;
    logic [2:0]        w_r;
`endif

    // Rotate requests so bit k corresponds to requester (ptr+k) mod NREQ; lowest k wins.
    always_comb begin
        w_rot2      = {req_valid, req_valid} >> r_ptr;
        w_rot       = w_rot2[NREQ-1:0];
        w_grant_any = 1'b0;
        w_sum       = '0;
        w_gidx      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_grant_any = 1'b1;
                w_sum       = SW'(r_ptr) + SW'(k);
                if (w_sum >= SW'(NREQ)) begin
                    w_sum = w_sum - SW'(NREQ);
                end
                w_gidx      = w_sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        w_xsel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_gidx == IDW'(k)) begin
                w_xsel = req_x[XW*k +: XW];
            end
        end
    end

    assign w_drain_b    = r_vb & rsp_ready;
    assign w_adv_a      = r_va & (~r_vb | w_drain_b);
    assign w_can_accept = ~r_va | w_adv_a;
    assign w_accept     = w_grant_any & w_can_accept;
    assign w_grant      = w_grant_any ? (NREQ'(1) << w_gidx) : '0;
    assign w_ptr_nxt    = (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + IDW'(1);

    // Held low while reset is asserted so nothing looks accepted during reset.
    assign req_ready    = w_grant & {NREQ{w_can_accept & rst_n}};

    div_64_5 u_div (
        .X (r_xa),
        .Q (w_q)
    );

`ifdef DIV5_SCHED_REM_OUT_EN
    // Remainder only needs the low three bits: x - 5q is known to lie in 0..4.
    assign w_r = r_xa[2:0] - 3'd5 * w_q[2:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xa  <= '0;
            r_ida <= '0;
            r_va  <= 1'b0;
            r_qb  <= '0;
            r_idb <= '0;
            r_vb  <= 1'b0;
            r_ptr <= '0;
`ifdef DIV5_SCHED_REM_OUT_EN
            r_rb  <= '0;
`endif
        end else begin
            r_va <= w_accept | (r_va & ~w_adv_a);
            r_vb <= w_adv_a | (r_vb & ~w_drain_b);
            if (w_accept) begin
                r_xa  <= w_xsel;
                r_ida <= w_gidx;
                r_ptr <= w_ptr_nxt;
            end
            if (w_adv_a) begin
                r_qb  <= w_q;
                r_idb <= r_ida;
`ifdef DIV5_SCHED_REM_OUT_EN
                r_rb  <= w_r;
`endif
            end
        end
    end

    assign rsp_valid = r_vb;
    assign rsp_q     = r_qb;
    assign rsp_id    = r_idb;
    assign busy      = r_va | r_vb;
`ifdef DIV5_SCHED_REM_OUT_EN
    assign rsp_r     = r_rb;
`endif

endmodule

// File: tb/tb_div5_rr_sched.sv
// Directed bench for div5_rr_sched: reset, latency, operand extremes, round robin, backpressure,
// mid-flight reset and an operand stream (plus remainder checks when DIV5_SCHED_REM_OUT_EN is defined).
module tb_div5_rr_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [255:0] req_x = '0;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [61:0]  rsp_q;
    logic [1:0]   rsp_id;
    logic         busy;
`ifdef DIV5_SCHED_REM_OUT_EN
    logic [2:0]   rsp_r;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] rr_x [4] = '{64'd1000, 64'd2003, 64'd3009, 64'd4014};
    logic [61:0] rr_q [4] = '{62'd200, 62'd400, 62'd601, 62'd802};

    div5_rr_sched #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_q     (rsp_q),
        .rsp_id    (rsp_id),
        .busy      (busy)
`ifdef DIV5_SCHED_REM_OUT_EN
        ,
        .rsp_r     (rsp_r)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic load_rr_x();
        for (int i = 0; i < 4; i++) req_x[64*i +: 64] = rr_x[i];
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_req_ready: got %b exp 0000", req_ready); end
        n_checks++; if (rsp_q !== 62'd0 || rsp_id !== 2'd0) begin n_errors++; $display("FAIL reset_data: got q=%0h id=%0d exp 0/0", rsp_q, rsp_id); end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL reset_release: got valid=%b busy=%b exp 0/0", rsp_valid, busy); end
    endtask

    task automatic test_single();
        req_x[63:0] = 64'd100;
        req_valid   = 4'b0001;
        rsp_ready   = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL single_ready: got %b exp 0001", req_ready); end
        tick();
        req_valid = '0;
        n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL single_t1: got valid=%b busy=%b exp 0/1", rsp_valid, busy); end
        tick();
        n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL single_t2_valid: got %b exp 1", rsp_valid); end
        n_checks++; if (rsp_q !== 62'd20 || rsp_id !== 2'd0) begin n_errors++; $display("FAIL single_t2_data: got q=%0d id=%0d exp 20/0", rsp_q, rsp_id); end
        tick();
        n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL single_t3: got valid=%b busy=%b exp 0/0", rsp_valid, busy); end
    endtask

    task automatic test_extremes();
        rsp_ready   = 1'b1;
        req_valid   = 4'b0001;
        req_x[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        req_x[63:0] = 64'd4;
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_q !== 62'h3333_3333_3333_3333) begin n_errors++; $display("FAIL ext_max: got valid=%b q=%0h exp 1/3333333333333333", rsp_valid, rsp_q); end
`ifdef DIV5_SCHED_REM_OUT_EN
        n_checks++; if (rsp_r !== 3'd0) begin n_errors++; $display("FAIL ext_max_r: got %0d exp 0", rsp_r); end
`endif
        req_x[63:0] = 64'd5;
        tick();
        req_valid = '0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_q !== 62'd0) begin n_errors++; $display("FAIL ext_4: got valid=%b q=%0d exp 1/0", rsp_valid, rsp_q); end
`ifdef DIV5_SCHED_REM_OUT_EN
        n_checks++; if (rsp_r !== 3'd4) begin n_errors++; $display("FAIL ext_4_r: got %0d exp 4", rsp_r); end
`endif
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_q !== 62'd1) begin n_errors++; $display("FAIL ext_5: got valid=%b q=%0d exp 1/1", rsp_valid, rsp_q); end
`ifdef DIV5_SCHED_REM_OUT_EN
        n_checks++; if (rsp_r !== 3'd0) begin n_errors++; $display("FAIL ext_5_r: got %0d exp 0", rsp_r); end
`endif
        tick();
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL ext_drain: got busy=%b exp 0", busy); end
    endtask

    task automatic test_round_robin();
        do_reset();
        load_rr_x();
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                req_valid = 4'hF;
                #1;
                n_checks++; if (req_ready !== (4'b0001 << (k % 4))) begin n_errors++; $display("FAIL rr_grant%0d: got %b exp %b", k, req_ready, 4'b0001 << (k % 4)); end
            end else begin
                req_valid = '0;
            end
            tick();
            if (k >= 1 && k <= 6) begin
                n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 1) % 4) || rsp_q !== rr_q[(k - 1) % 4]) begin
                    n_errors++; $display("FAIL rr_rsp%0d: got v=%b id=%0d q=%0d exp 1/%0d/%0d", k - 1, rsp_valid, rsp_id, rsp_q, (k - 1) % 4, rr_q[(k - 1) % 4]);
                end
            end
        end
        n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL rr_end: got valid=%b busy=%b exp 0/0", rsp_valid, busy); end
    endtask

    task automatic test_backpressure();
        int exp_id [5] = '{0, 1, 2, 3, 0};
        do_reset();
        load_rr_x();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL bp_acc0: got %b exp 0001", req_ready); end
        tick();
        n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL bp_acc1: got %b exp 0010", req_ready); end
        tick();
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL bp_full_ready%0d: got %b exp 0000", c, req_ready); end
            n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_q !== 62'd200 || busy !== 1'b1) begin
                n_errors++; $display("FAIL bp_hold%0d: got v=%b id=%0d q=%0d busy=%b exp 1/0/200/1", c, rsp_valid, rsp_id, rsp_q, busy);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL bp_release_ready: got %b exp 0100", req_ready); end
        for (int j = 0; j < 5; j++) begin
            if (j >= 3) req_valid = '0;
            n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id[j]) || rsp_q !== rr_q[exp_id[j]]) begin
                n_errors++; $display("FAIL bp_order%0d: got v=%b id=%0d q=%0d exp 1/%0d/%0d", j, rsp_valid, rsp_id, rsp_q, exp_id[j], rr_q[exp_id[j]]);
            end
            tick();
        end
        n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL bp_end: got valid=%b busy=%b exp 0/0", rsp_valid, busy); end
    endtask

    task automatic test_reset_midflight();
        load_rr_x();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        tick();
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 4'b0000) begin
            n_errors++; $display("FAIL mf_full: got v=%b busy=%b ready=%b exp 1/1/0000", rsp_valid, busy, req_ready);
        end
        rst_n = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL mf_async: got valid=%b busy=%b exp 0/0", rsp_valid, busy); end
        n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL mf_ready_in_reset: got %b exp 0000", req_ready); end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL mf_stale: got valid=%b busy=%b exp 0/0", rsp_valid, busy); end
        req_valid = 4'hF;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL mf_ptr: got %b exp 0001", req_ready); end
        tick();
        req_valid = '0;
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_q !== 62'd200) begin
            n_errors++; $display("FAIL mf_fresh: got v=%b id=%0d q=%0d exp 1/0/200", rsp_valid, rsp_id, rsp_q);
        end
        tick();
    endtask

`ifdef DIV5_SCHED_REM_OUT_EN
    task automatic test_rem();
        rsp_ready   = 1'b1;
        req_valid   = 4'b0001;
        req_x[63:0] = 64'd14;
        tick();
        req_valid = '0;
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_q !== 62'd2 || rsp_r !== 3'd4) begin
            n_errors++; $display("FAIL rem_14: got v=%b q=%0d r=%0d exp 1/2/4", rsp_valid, rsp_q, rsp_r);
        end
        tick();
    endtask
    localparam int N_STREAM = 10000;
`else
    localparam int N_STREAM = 1000;
`endif

    task automatic test_stream();
        logic [63:0] exp_q [$];
        logic [63:0] x;
        logic [63:0] e;
        rsp_ready = 1'b1;
        for (int n = 0; n < N_STREAM + 4; n++) begin
            if (n < N_STREAM) begin
                x = {$urandom, $urandom};
                if (n % 97 == 0) x = 64'hFFFF_FFFF_FFFF_FFFF - 64'(n % 7);
                req_x[63:0] = x;
                req_valid   = 4'b0001;
                #1;
                if (req_ready[0] === 1'b1) exp_q.push_back(x);
            end else begin
                req_valid = '0;
            end
            tick();
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++; $display("FAIL stream_extra: got q=%0h exp no response", rsp_q);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++; if (rsp_q !== 62'(e / 64'd5)) begin n_errors++; $display("FAIL stream_q: x=%0h got %0h exp %0h", e, rsp_q, 62'(e / 64'd5)); end
`ifdef DIV5_SCHED_REM_OUT_EN
                    n_checks++; if (rsp_r !== 3'(e % 64'd5)) begin n_errors++; $display("FAIL stream_r: x=%0h got %0d exp %0d", e, rsp_r, 3'(e % 64'd5)); end
`endif
                end
            end
        end
        n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL stream_lost: got %0d outstanding exp 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_extremes();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
`ifdef DIV5_SCHED_REM_OUT_EN
        test_rem();
`endif
        test_stream();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
